// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU results are force-slotted after STARVE_LIMIT lost cycles.
// Optional combinational bypass outputs (byp_valid/byp_addr/byp_data) are enabled by defining WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_wr_en,
    input  logic [ADDR_W-1:0] pipe_wr_addr,
    input  logic [DATA_W-1:0] pipe_wr_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              grant_src
`ifdef WB_ARB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0] byp_data
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(STARVE_LIMIT);

    typedef enum logic {
        PIPE_PRI = 1'b0,
        FORCE    = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W:0]    w_cnt_inc;

    logic              w_pipe_win;
    logic              w_mdu_win;
    logic              w_win;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_grant_src;

    // Winner selection: in FORCE the pipeline request is masked so the MDU gets the slot.
    always_comb begin
        w_pipe_win = (r_state == PIPE_PRI) && pipe_wr_en;
        w_mdu_win  = mdu_valid && !w_pipe_win;
        w_win      = w_pipe_win || w_mdu_win;
        w_win_addr = w_pipe_win ? pipe_wr_addr : mdu_addr;
        w_win_data = w_pipe_win ? pipe_wr_data : mdu_data;
    end

    assign mdu_ready  = w_mdu_win && !reset;
    assign stall_pipe = (r_state == FORCE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PIPE_PRI;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
        case (r_state)
            PIPE_PRI: begin
                if (!mdu_valid || w_mdu_win) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc >= LIMIT) begin
                    // Losing again would hit the limit: reserve the next cycle for the MDU.
                    w_state_nxt = FORCE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                end
            end
            FORCE: begin
                w_state_nxt = PIPE_PRI;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = PIPE_PRI;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Register-0 winners are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_grant_src <= 1'b0;
        end else begin
            r_we <= w_win && (w_win_addr != '0);
            if (w_win) begin
                r_waddr     <= w_win_addr;
                r_wdata     <= w_win_data;
                r_grant_src <= w_mdu_win;
            end
        end
    end

    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign grant_src = r_grant_src;

`ifdef WB_ARB_BYPASS_EN
    assign byp_valid = w_win && (w_win_addr != '0);
    assign byp_addr  = w_win_addr;
    assign byp_data  = w_win_data;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected write-port state is queued per driven cycle and compared after the edge.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_wr_en;
    logic [AW-1:0] pipe_wr_addr;
    logic [DW-1:0] pipe_wr_data;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          stall_pipe;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          grant_src;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          src;
        logic          stall;
    } obs_t;

    obs_t exp_q[$];
    obs_t expv;
    obs_t act;
    int   errors = 0;
    int   checks = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_addr (pipe_wr_addr),
        .pipe_wr_data (pipe_wr_data),
        .mdu_valid    (mdu_valid),
        .mdu_addr     (mdu_addr),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .stall_pipe   (stall_pipe),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .grant_src    (grant_src)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b1;
        pipe_wr_en = 1'b0; pipe_wr_addr = '0; pipe_wr_data = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
        repeat (2) @(posedge clk);
        #1;
        act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
        checks++;
        if (act !== '0) begin
            errors++; $display("FAIL reset_state: got %h want %h", act, obs_t'(0));
        end
        mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_data = 32'h0BAD_0004;
        #1;
        checks++;
        if (mdu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_mdu_ready: got %b want 0", mdu_ready);
        end
        mdu_valid = 1'b0;
        reset = 1'b0;
        exp_q.push_back({1'b0, 5'd0, 32'h0, 1'b0, 1'b0});
        @(posedge clk); #1;
        expv = exp_q.pop_front();
        act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
        checks++;
        if (act !== expv) begin
            errors++; $display("FAIL reset_idle: got %h want %h", act, expv);
        end
    endtask

    task automatic test_pipe_only;
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'hDEAD_BEEF;
        #2;
        checks++;
        if (mdu_ready !== 1'b0) begin
            errors++; $display("FAIL pipe_only_ready: got %b want 0", mdu_ready);
        end
        exp_q.push_back({1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0});
        @(posedge clk); #1;
        pipe_wr_en = 1'b0;
        expv = exp_q.pop_front();
        act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
        checks++;
        if (act !== expv) begin
            errors++; $display("FAIL pipe_only_write: got %h want %h", act, expv);
        end
        exp_q.push_back({1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0});
        @(posedge clk); #1;
        expv = exp_q.pop_front();
        act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
        checks++;
        if (act !== expv) begin
            errors++; $display("FAIL idle_hold: got %h want %h", act, expv);
        end
    endtask

    task automatic test_mdu_only;
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h1234_5678;
        #2;
        checks++;
        if (mdu_ready !== 1'b1) begin
            errors++; $display("FAIL mdu_only_ready: got %b want 1", mdu_ready);
        end
        exp_q.push_back({1'b1, 5'd9, 32'h1234_5678, 1'b1, 1'b0});
        @(posedge clk); #1;
        mdu_valid = 1'b0;
        expv = exp_q.pop_front();
        act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
        checks++;
        if (act !== expv) begin
            errors++; $display("FAIL mdu_only_write: got %h want %h", act, expv);
        end
    endtask

    task automatic test_starvation;
        pipe_wr_en = 1'b1;
        mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'hA5A5_0003;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) mdu_valid = 1'b0;
            pipe_wr_addr = 5'(10 + c);
            pipe_wr_data = 32'h1000_0000 + 32'(c);
            #2;
            checks++;
            if (mdu_ready !== (c == 4)) begin
                errors++; $display("FAIL starve_ready c%0d: got %b want %b", c, mdu_ready, (c == 4));
            end
            checks++;
            if (stall_pipe !== (c == 4)) begin
                errors++; $display("FAIL starve_stall c%0d: got %b want %b", c, stall_pipe, (c == 4));
            end
            if (c == 4) exp_q.push_back({1'b1, 5'd3, 32'hA5A5_0003, 1'b1, 1'b0});
            else        exp_q.push_back({1'b1, 5'(10 + c), 32'h1000_0000 + 32'(c), 1'b0, (c == 3)});
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
            checks++;
            if (act !== expv) begin
                errors++; $display("FAIL starve_write c%0d: got %h want %h", c, act, expv);
            end
        end
        pipe_wr_en = 1'b0;
    endtask

    task automatic test_zero_reg;
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 32'hFFFF_FFFF;
        exp_q.push_back({1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0});
        @(posedge clk); #1;
        pipe_wr_en = 1'b0;
        expv = exp_q.pop_front();
        checks++;
        if ({rf_we, stall_pipe} !== {expv.we, expv.stall}) begin
            errors++; $display("FAIL zero_pipe: got we=%b stall=%b want we=0 stall=0", rf_we, stall_pipe);
        end
        mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h5555_AAAA;
        #2;
        checks++;
        if (mdu_ready !== 1'b1) begin
            errors++; $display("FAIL zero_mdu_ready: got %b want 1", mdu_ready);
        end
        exp_q.push_back({1'b0, 5'd0, 32'h5555_AAAA, 1'b1, 1'b0});
        @(posedge clk); #1;
        mdu_valid = 1'b0;
        expv = exp_q.pop_front();
        checks++;
        if ({rf_we, stall_pipe} !== {expv.we, expv.stall}) begin
            errors++; $display("FAIL zero_mdu: got we=%b stall=%b want we=0 stall=0", rf_we, stall_pipe);
        end
    endtask

    task automatic test_back_to_back;
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd12; pipe_wr_data = 32'hCAFE_0012;
        mdu_valid = 1'b1; mdu_addr = 5'd13; mdu_data = 32'hBEEF_0013;
        #2;
        checks++;
        if (mdu_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_contend_ready: got %b want 0", mdu_ready);
        end
        exp_q.push_back({1'b1, 5'd12, 32'hCAFE_0012, 1'b0, 1'b0});
        @(posedge clk); #1;
        pipe_wr_en = 1'b0;
        expv = exp_q.pop_front();
        act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
        checks++;
        if (act !== expv) begin
            errors++; $display("FAIL b2b_pipe: got %h want %h", act, expv);
        end
        #1;
        checks++;
        if (mdu_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_mdu_ready: got %b want 1", mdu_ready);
        end
        exp_q.push_back({1'b1, 5'd13, 32'hBEEF_0013, 1'b1, 1'b0});
        @(posedge clk); #1;
        mdu_valid = 1'b0;
        expv = exp_q.pop_front();
        act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
        checks++;
        if (act !== expv) begin
            errors++; $display("FAIL b2b_mdu: got %h want %h", act, expv);
        end
    endtask

    task automatic test_reset_in_force;
        pipe_wr_en = 1'b1;
        mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h7777_0007;
        for (int c = 0; c < 5; c++) begin
            pipe_wr_addr = 5'(20 + c);
            pipe_wr_data = 32'h2000_0000 + 32'(c);
            if (c == 4) reset = 1'b1;
            #2;
            checks++;
            if (mdu_ready !== 1'b0) begin
                errors++; $display("FAIL rif_ready c%0d: got %b want 0", c, mdu_ready);
            end
            checks++;
            if (stall_pipe !== (c == 4)) begin
                errors++; $display("FAIL rif_stall c%0d: got %b want %b", c, stall_pipe, (c == 4));
            end
            if (c == 4) exp_q.push_back({1'b0, 5'd0, 32'h0, 1'b0, 1'b0});
            else        exp_q.push_back({1'b1, 5'(20 + c), 32'h2000_0000 + 32'(c), 1'b0, (c == 3)});
            @(posedge clk); #1;
            expv = exp_q.pop_front();
            act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
            checks++;
            if (act !== expv) begin
                errors++; $display("FAIL rif_write c%0d: got %h want %h", c, act, expv);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            pipe_wr_addr = 5'(25 + c);
            pipe_wr_data = 32'h3000_0000 + 32'(c);
            #2;
            checks++;
            if (mdu_ready !== (c == 4)) begin
                errors++; $display("FAIL rif2_ready c%0d: got %b want %b", c, mdu_ready, (c == 4));
            end
            checks++;
            if (stall_pipe !== (c == 4)) begin
                errors++; $display("FAIL rif2_stall c%0d: got %b want %b", c, stall_pipe, (c == 4));
            end
            if (c == 4) exp_q.push_back({1'b1, 5'd7, 32'h7777_0007, 1'b1, 1'b0});
            else        exp_q.push_back({1'b1, 5'(25 + c), 32'h3000_0000 + 32'(c), 1'b0, (c == 3)});
            @(posedge clk); #1;
            if (c == 4) mdu_valid = 1'b0;
            expv = exp_q.pop_front();
            act = {rf_we, rf_waddr, rf_wdata, grant_src, stall_pipe};
            checks++;
            if (act !== expv) begin
                errors++; $display("FAIL rif2_write c%0d: got %h want %h", c, act, expv);
            end
        end
        pipe_wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_mdu_only();
        test_starvation();
        test_zero_reg();
        test_back_to_back();
        test_reset_in_force();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
